// File: rtl/ext_intr_arbiter.sv
// External-interrupt gateway and priority arbiter producing meip (mip[11]).
// Level sources latch into pending, are claimed by software, and re-arm on completion.
module ext_intr_arbiter #(
   parameter int NSRC   = 8,
   parameter int PRIO_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NSRC-1:0]   src_irq,
   input  logic              cfg_we,
   input  logic [5:0]        cfg_addr,
   input  logic [31:0]       cfg_wdata,
   output logic [31:0]       cfg_rdata,
   input  logic              claim_req,
   output logic              claim_ack,
   output logic [4:0]        claim_id,
   input  logic              complete_valid,
   input  logic [4:0]        complete_id,
   output logic              meip
);

   logic [NSRC-1:0]   r_pending;
   logic [NSRC-1:0]   r_inService;
   logic [PRIO_W-1:0] r_prio [NSRC];
   logic [PRIO_W-1:0] r_threshold;
   logic [NSRC-1:0]   r_enable;
   logic [4:0]        r_bestId;
   logic              r_meip;
   logic              r_claimAck;
   logic [4:0]        r_claimId;

   logic [NSRC-1:0]   w_claimMask;
   logic [NSRC-1:0]   w_completeMask;
   logic [NSRC-1:0]   w_inServiceNext;
   logic [NSRC-1:0]   w_pendingNext;
   logic [PRIO_W-1:0] w_prioNext [NSRC];
   logic [PRIO_W-1:0] w_thresholdNext;
   logic [NSRC-1:0]   w_enableNext;
   logic [4:0]        w_bestId;
   logic [PRIO_W-1:0] w_bestPrio;
   logic              w_unused;

   assign w_unused = ^cfg_wdata;

   // Decoding through the ID compare drops ID 0 and out-of-range IDs for free.
   always_comb begin
      w_claimMask    = '0;
      w_completeMask = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (claim_req && r_bestId == 5'(i + 1))
            w_claimMask[i] = 1'b1;
         if (complete_valid && complete_id == 5'(i + 1))
            w_completeMask[i] = 1'b1;
      end
   end

   assign w_inServiceNext = (r_inService & ~w_completeMask) | w_claimMask;
   assign w_pendingNext   = (r_pending | (src_irq & ~w_inServiceNext)) & ~w_claimMask;

   assign w_thresholdNext = (cfg_we && cfg_addr == 6'd0)  ? cfg_wdata[PRIO_W-1:0] : r_threshold;
   assign w_enableNext    = (cfg_we && cfg_addr == 6'd32) ? cfg_wdata[NSRC-1:0]   : r_enable;

   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         w_prioNext[i] = (cfg_we && cfg_addr == 6'(i + 1)) ? cfg_wdata[PRIO_W-1:0] : r_prio[i];
      end
   end

   // Strict greater-than while scanning upward keeps the lowest ID on ties.
   always_comb begin
      w_bestId   = '0;
      w_bestPrio = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (w_pendingNext[i] && w_enableNext[i] &&
             (w_prioNext[i] > w_thresholdNext) && (w_prioNext[i] > w_bestPrio)) begin
            w_bestId   = 5'(i + 1);
            w_bestPrio = w_prioNext[i];
         end
      end
   end

   always_comb begin
      cfg_rdata = '0;
      if (cfg_addr == 6'd0)
         cfg_rdata[PRIO_W-1:0] = r_threshold;
      else if (cfg_addr == 6'd32)
         cfg_rdata[NSRC-1:0] = r_enable;
      for (int i = 0; i < NSRC; i++) begin
         if (cfg_addr == 6'(i + 1))
            cfg_rdata[PRIO_W-1:0] = r_prio[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending   <= '0;
         r_inService <= '0;
         r_threshold <= '0;
         r_enable    <= '0;
         r_bestId    <= '0;
         r_meip      <= 1'b0;
         r_claimAck  <= 1'b0;
         r_claimId   <= '0;
         for (int i = 0; i < NSRC; i++)
            r_prio[i] <= '0;
      end else begin
         r_pending   <= w_pendingNext;
         r_inService <= w_inServiceNext;
         r_threshold <= w_thresholdNext;
         r_enable    <= w_enableNext;
         r_bestId    <= w_bestId;
         r_meip      <= (w_bestId != 5'd0);
         r_claimAck  <= claim_req;
         r_claimId   <= claim_req ? r_bestId : 5'd0;
         for (int i = 0; i < NSRC; i++)
            r_prio[i] <= w_prioNext[i];
      end
   end

   assign claim_ack = r_claimAck;
   assign claim_id  = r_claimId;
   assign meip      = r_meip;

endmodule

// File: tb/tb_ext_intr_arbiter.sv
// Bench for ext_intr_arbiter: directed scenarios followed by random traffic,
// all compared against a rule-level model of pending/in-service/config state.
module tb_ext_intr_arbiter;

   localparam int NSRC   = 8;
   localparam int PRIO_W = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [NSRC-1:0]   src_irq;
   logic              cfg_we;
   logic [5:0]        cfg_addr;
   logic [31:0]       cfg_wdata;
   logic [31:0]       cfg_rdata;
   logic              claim_req;
   logic              claim_ack;
   logic [4:0]        claim_id;
   logic              complete_valid;
   logic [4:0]        complete_id;
   logic              meip;

   int checks   = 0;
   int failures = 0;

   // Reference state indexed by source ID (entry 0 unused).
   bit mPend  [NSRC+1];
   bit mInSvc [NSRC+1];
   bit mEn    [NSRC+1];
   int mPrio  [NSRC+1];
   int mThr;
   int mBest;
   bit expAck;
   int expId;

   ext_intr_arbiter #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
      .clk(clk),
      .reset(reset),
      .src_irq(src_irq),
      .cfg_we(cfg_we),
      .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata),
      .cfg_rdata(cfg_rdata),
      .claim_req(claim_req),
      .claim_ack(claim_ack),
      .claim_id(claim_id),
      .complete_valid(complete_valid),
      .complete_id(complete_id),
      .meip(meip)
   );

   always #5 clk = ~clk;

   function automatic void modelReset();
      for (int id = 0; id <= NSRC; id++) begin
         mPend[id]  = 1'b0;
         mInSvc[id] = 1'b0;
         mEn[id]    = 1'b0;
         mPrio[id]  = 0;
      end
      mThr   = 0;
      mBest  = 0;
      expAck = 1'b0;
      expId  = 0;
   endfunction

   // Highest priority level first, then lowest ID within that level.
   function automatic int modelBest();
      for (int p = (1 << PRIO_W) - 1; p > mThr; p--)
         for (int id = 1; id <= NSRC; id++)
            if (mPend[id] && mEn[id] && mPrio[id] == p)
               return id;
      return 0;
   endfunction

   function automatic logic [31:0] modelRead(input int addr);
      logic [31:0] v;
      v = '0;
      if (addr == 0)
         v = 32'(mThr);
      else if (addr >= 1 && addr <= NSRC)
         v = 32'(mPrio[addr]);
      else if (addr == 32)
         for (int id = 1; id <= NSRC; id++)
            v[id-1] = mEn[id];
      return v;
   endfunction

   function automatic void modelStep(input logic [NSRC-1:0] src, input bit claim, input bit cv,
                                     input int cid, input bit we, input int addr, input logic [31:0] wdata);
      int claimed;
      expAck  = claim;
      expId   = claim ? mBest : 0;
      claimed = claim ? mBest : 0;
      if (cv && cid >= 1 && cid <= NSRC)
         mInSvc[cid] = 1'b0;
      if (claimed != 0) begin
         mPend[claimed]  = 1'b0;
         mInSvc[claimed] = 1'b1;
      end
      for (int id = 1; id <= NSRC; id++)
         if (src[id-1] && !mInSvc[id])
            mPend[id] = 1'b1;
      if (we) begin
         if (addr == 0)
            mThr = int'(wdata) & ((1 << PRIO_W) - 1);
         else if (addr >= 1 && addr <= NSRC)
            mPrio[addr] = int'(wdata) & ((1 << PRIO_W) - 1);
         else if (addr == 32)
            for (int id = 1; id <= NSRC; id++)
               mEn[id] = wdata[id-1];
      end
      mBest = modelBest();
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: read-check before the edge, output-check after it.
   task automatic applyStimulus(input logic [NSRC-1:0] src, input bit claim, input bit cv,
                                input int cid, input bit we, input int addr, input logic [31:0] wdata);
      @(negedge clk);
      src_irq        = src;
      claim_req      = claim;
      complete_valid = cv;
      complete_id    = 5'(cid);
      cfg_we         = we;
      cfg_addr       = 6'(addr);
      cfg_wdata      = wdata;
      #1;
      checkOutput("cfg_rdata", cfg_rdata, modelRead(addr));
      modelStep(src, claim, cv, cid, we, addr, wdata);
      @(posedge clk);
      #1;
      checkOutput("meip", 32'(meip), 32'(mBest != 0));
      checkOutput("claim_ack", 32'(claim_ack), 32'(expAck));
      checkOutput("claim_id", 32'(claim_id), 32'(expId));
   endtask

   initial begin
      reset          = 1'b1;
      src_irq        = '0;
      cfg_we         = 1'b0;
      cfg_addr       = '0;
      cfg_wdata      = '0;
      claim_req      = 1'b0;
      complete_valid = 1'b0;
      complete_id    = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_meip", 32'(meip), 0);
      checkOutput("rst_ack", 32'(claim_ack), 0);
      checkOutput("rst_id", 32'(claim_id), 0);
      checkOutput("rst_rdata", cfg_rdata, 0);
      @(negedge clk);
      reset = 1'b0;

      // Single pulsed source, latched and claimed.
      applyStimulus(8'h00, 0, 0, 0, 1, 32, 32'hFF);
      applyStimulus(8'h00, 0, 0, 0, 1, 3, 32'd2);
      applyStimulus(8'h00, 0, 0, 0, 1, 0, 32'd0);
      applyStimulus(8'h04, 0, 0, 0, 0, 3, 32'd0);
      checkOutput("t1_meip_rise", 32'(meip), 1);
      applyStimulus(8'h00, 0, 0, 0, 0, 32, 32'd0);
      checkOutput("t1_meip_hold", 32'(meip), 1);
      applyStimulus(8'h00, 1, 0, 0, 0, 0, 32'd0);
      checkOutput("t1_claim_id", 32'(claim_id), 3);
      checkOutput("t1_meip_clear", 32'(meip), 0);

      // Priority ordering with a tie between IDs 2 and 5.
      applyStimulus(8'h00, 0, 0, 0, 1, 2, 32'd5);
      applyStimulus(8'h00, 0, 0, 0, 1, 5, 32'd5);
      applyStimulus(8'h00, 0, 0, 0, 1, 7, 32'd6);
      applyStimulus(8'h52, 0, 0, 0, 0, 7, 32'd0);
      applyStimulus(8'h00, 1, 0, 0, 0, 0, 32'd0);
      checkOutput("t2_first", 32'(claim_id), 7);
      applyStimulus(8'h00, 1, 0, 0, 0, 0, 32'd0);
      checkOutput("t2_second", 32'(claim_id), 2);
      applyStimulus(8'h00, 1, 0, 0, 0, 0, 32'd0);
      checkOutput("t2_third", 32'(claim_id), 5);
      applyStimulus(8'h00, 1, 0, 0, 0, 0, 32'd0);
      checkOutput("t2_none_id", 32'(claim_id), 0);
      checkOutput("t2_none_ack", 32'(claim_ack), 1);
      applyStimulus(8'h00, 0, 1, 7, 0, 0, 32'd0);
      applyStimulus(8'h00, 0, 1, 2, 0, 0, 32'd0);
      applyStimulus(8'h00, 0, 1, 5, 0, 0, 32'd0);
      applyStimulus(8'h00, 0, 1, 3, 0, 0, 32'd0);

      // Held source stays quiet while in service, re-pends after completion.
      applyStimulus(8'h00, 0, 0, 0, 1, 4, 32'd1);
      applyStimulus(8'h08, 0, 0, 0, 0, 4, 32'd0);
      applyStimulus(8'h08, 1, 0, 0, 0, 0, 32'd0);
      checkOutput("t3_claim_id", 32'(claim_id), 4);
      applyStimulus(8'h08, 0, 0, 0, 0, 0, 32'd0);
      checkOutput("t3_no_repend", 32'(meip), 0);
      applyStimulus(8'h08, 0, 1, 0, 0, 0, 32'd0);
      checkOutput("t3_cid0", 32'(meip), 0);
      applyStimulus(8'h08, 0, 1, 9, 0, 0, 32'd0);
      checkOutput("t3_cid9", 32'(meip), 0);
      applyStimulus(8'h08, 0, 1, 4, 0, 0, 32'd0);
      checkOutput("t3_repend", 32'(meip), 1);
      applyStimulus(8'h00, 1, 0, 0, 0, 0, 32'd0);
      applyStimulus(8'h00, 0, 1, 4, 0, 0, 32'd0);

      // Threshold and enable gating of a pending source.
      applyStimulus(8'h00, 0, 0, 0, 1, 0, 32'd3);
      applyStimulus(8'h00, 0, 0, 0, 1, 1, 32'd3);
      applyStimulus(8'h01, 0, 0, 0, 0, 1, 32'd0);
      checkOutput("t4_below_thr", 32'(meip), 0);
      applyStimulus(8'h00, 0, 0, 0, 1, 0, 32'd2);
      checkOutput("t4_thr_lowered", 32'(meip), 1);
      applyStimulus(8'h00, 0, 0, 0, 1, 32, 32'hFE);
      checkOutput("t4_disabled", 32'(meip), 0);
      applyStimulus(8'h00, 0, 0, 0, 1, 32, 32'hFF);
      checkOutput("t4_reenabled", 32'(meip), 1);
      applyStimulus(8'h00, 1, 0, 0, 0, 32, 32'd0);
      checkOutput("t4_claim_id", 32'(claim_id), 1);
      applyStimulus(8'h00, 0, 1, 1, 0, 0, 32'd0);

      // Same-cycle completion of ID 6 and claim of ID 1.
      applyStimulus(8'h00, 0, 0, 0, 1, 6, 32'd4);
      applyStimulus(8'h20, 0, 0, 0, 0, 6, 32'd0);
      applyStimulus(8'h00, 1, 0, 0, 0, 0, 32'd0);
      checkOutput("t5_claim6", 32'(claim_id), 6);
      applyStimulus(8'h01, 0, 0, 0, 0, 0, 32'd0);
      applyStimulus(8'h00, 1, 1, 6, 0, 0, 32'd0);
      checkOutput("t5_claim1", 32'(claim_id), 1);
      checkOutput("t5_meip", 32'(meip), 0);
      applyStimulus(8'h20, 0, 0, 0, 0, 0, 32'd0);
      checkOutput("t5_id6_free", 32'(meip), 1);
      applyStimulus(8'h00, 1, 0, 0, 0, 0, 32'd0);
      applyStimulus(8'h00, 0, 1, 6, 0, 0, 32'd0);
      applyStimulus(8'h00, 0, 1, 1, 0, 0, 32'd0);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         logic [NSRC-1:0] rSrc;
         bit   rClaim, rCv, rWe;
         int   rCid, rAddr, sel;
         logic [31:0] rData;
         rSrc   = NSRC'($urandom & $urandom);
         rClaim = ($urandom_range(0, 9) < 3);
         rCv    = ($urandom_range(0, 9) < 4);
         rCid   = $urandom_range(0, NSRC + 3);
         rWe    = ($urandom_range(0, 9) < 2);
         sel    = $urandom_range(0, 11);
         rAddr  = (sel == 0) ? 0 : (sel <= NSRC) ? sel : (sel == NSRC + 1) ? 32 : $urandom_range(33, 63);
         rData  = $urandom;
         applyStimulus(rSrc, rClaim, rCv, rCid, rWe, rAddr, rData);
      end

      // Reset between a claim request and its acknowledge.
      applyStimulus(8'h00, 0, 0, 0, 1, 0, 32'd0);
      applyStimulus(8'h00, 0, 0, 0, 1, 32, 32'hFF);
      applyStimulus(8'h00, 0, 0, 0, 1, 8, 32'd7);
      applyStimulus(8'h80, 0, 1, 8, 0, 8, 32'd0);
      checkOutput("t6_meip_before", 32'(meip), 1);
      @(negedge clk);
      src_irq        = '0;
      complete_valid = 1'b0;
      cfg_we         = 1'b0;
      claim_req      = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t6_meip_async", 32'(meip), 0);
      @(posedge clk);
      #1;
      claim_req = 1'b0;
      checkOutput("t6_ack", 32'(claim_ack), 0);
      checkOutput("t6_meip", 32'(meip), 0);
      checkOutput("t6_id", 32'(claim_id), 0);
      for (int a = 0; a < 64; a++) begin
         cfg_addr = 6'(a);
         #1;
         checkOutput("t6_rdata_zero", cfg_rdata, 0);
      end
      modelReset();
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(8'h00, 1, 0, 0, 0, 8, 32'd0);
      checkOutput("t6_post_id", 32'(claim_id), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ext_intr_arbiter.md
# ext_intr_arbiter

External-interrupt arbiter and gateway that turns NSRC level-sensitive platform interrupt lines into the single machine external-interrupt pending bit (mip[11]) consumed by the CSR/trap logic. It holds per-source priority, a global threshold and an enable mask, selects the highest-priority eligible source, and runs a claim/complete handshake with the trap handler software path so each source is serviced exactly once per assertion. It sits between the platform interrupt wires and the CSR file, feeding `meip`.

## Interface
Parameters:
- NSRC, 8, number of interrupt sources (1..31); source IDs are 1..NSRC, ID 0 means "none"
- PRIO_W, 3, width of priority and threshold fields

Ports:
- clk  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- src_irq  in  NSRC  level interrupt lines, synchronous to clk; bit i is source ID i+1
- cfg_we  in  1  config write strobe
- cfg_addr  in  6  config address: 0 threshold, 1..NSRC priority of that ID, 32 enable mask
- cfg_wdata  in  32  config write data (low PRIO_W or low NSRC bits used)
- cfg_rdata  out  32  combinational read of cfg_addr; unused bits and unmapped addresses read 0
- claim_req  in  1  one-cycle claim request
- claim_ack  out  1  one-cycle pulse, cycle after claim_req
- claim_id  out  5  claimed ID, valid with claim_ack (0 = nothing claimed)
- complete_valid  in  1  one-cycle completion strobe
- complete_id  in  5  ID being completed
- meip  out  1  external interrupt pending, to CSR mip[11]

## Operation
- Per-source state: pending[i], in_service[i], prio[i]; global: threshold, enable[NSRC-1:0].
- Gateway: pending[i] sets when src_irq[i]=1, pending[i]=0 and in_service[i]=0. pending is never cleared by src_irq falling; only by claim.
- Eligible(i) = pending[i] & enable[i] & (prio[i] > threshold). prio 0 is never eligible.
- Arbitration: best_id = eligible source with largest prio; ties go to lowest ID; 0 if none. best_id and meip (= best_id != 0) are registered, computed from the next-state values of pending, prio, threshold, enable in the same cycle they are updated.
- Claim (claim_req=1 at cycle T): claim_ack=1, claim_id=best_id (register value at T) at T+1; if best_id!=0, pending cleared and in_service set for that ID at T+1. If best_id=0, no state changes, claim_id=0.
- Complete: clears in_service[complete_id] when set; complete_id 0, >NSRC or not in service is ignored silently. Source can re-pend the cycle after completion if src_irq still high.
- Simultaneous claim and complete: both applied; if same ID, claim wins (in_service stays 1).
- Config write: applied at next edge; writes to addr 0 mask to PRIO_W bits, addr 32 to NSRC bits; writes to unmapped addresses ignored. cfg_we concurrent with claim: both take effect; arbitration uses post-write values.
- Disabling a pending source keeps it pending; it reappears when re-enabled.

## Timing
- Reset values: all pending, in_service, prio, threshold, enable = 0; best_id=0; meip=0; claim_ack=0; claim_id=0.
- src_irq rise at T (enabled, prio>threshold) -> meip=1 at T+1.
- claim_req at T -> claim_ack/claim_id at T+1; meip and best_id at T+1 already exclude the claimed source, so back-to-back claim_req on T and T+1 return distinct IDs.
- Config change at T -> meip reflects it at T+1.
- reset asserted mid-handshake: all state cleared immediately; any outstanding claim is dropped and claim_ack is not produced.
- claim_ack is a strict one-cycle pulse per claim_req; claim_req held high claims once per cycle.

## Test plan
- Reset, enable=0xFF, prio[3]=2, threshold=0, pulse src_irq[2] one cycle -> meip=1 next cycle and stays 1 after src_irq drops; claim -> claim_id=3, meip=0 same cycle as ack.
- prio[2]=5, prio[5]=5, prio[7]=6, raise sources 2,5,7 together -> successive claims return 7, 2, 5, then 0 with claim_ack=1.
- Claimed ID 4 with src_irq[3] held high -> no re-pend while in service; complete_id=4 -> meip=1 one cycle later; complete_id=0 and 9 -> no state change.
- threshold=3, prio[1]=3 pending -> meip=0; write threshold=2 -> meip=1 next cycle; write enable bit 0 = 0 -> meip=0, re-enable -> meip=1.
- Same-cycle claim and complete of ID 6 (ID 6 in service and best_id=6 again is impossible; use ID 6 complete + claim of ID 1) -> ID 6 freed, ID 1 in service, claim_id=1.
- Assert reset between claim_req and claim_ack -> claim_ack=0, meip=0, all cfg_rdata reads 0.
